// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clock divider and its monitors.
//   state_e     - period meter FSM states
//   DIV_DEFAULT - default divide ratio shared with the divider
//   sat_max     - all-ones value of a w-bit counter
package clk_div_pkg;
   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;
   localparam int DIV_DEFAULT = 16;
   function automatic int unsigned sat_max(input int unsigned w);
      return (w >= 32) ? 32'hffff_ffff : (32'd1 << w) - 32'd1;
   endfunction
endpackage

// File: rtl/edge_det.sv
// edge_det: registers a same-clock flag and reports its rising/falling edges.
//   clk, rst - clock and synchronous active-high reset
//   d        - flag input
//   rise     - d is high now and was low last cycle
//   fall     - d is low now and was high last cycle
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic flag_q, flag_d;
   logic mask_q, mask_d;
   always_comb begin
      flag_d = d;
      // remembers a flag that was already high at the reset edge so that
      // it is not mistaken for a rise in the first cycle after reset
      mask_d = rst & d;
      rise   = d & ~flag_q & ~mask_q;
      fall   = ~d & flag_q;
   end
   always_ff @(posedge clk) begin
      flag_q <= rst ? 1'b0 : flag_d;
      mask_q <= mask_d;
   end
endmodule

// File: rtl/div_period_meter.sv
// div_period_meter: measures period and high time of a divider flag and checks lock.
//   clk, rst   - clock and synchronous active-high reset
//   en         - measurement enable, 0 forces IDLE
//   flag_in    - divider output, synchronous to clk
//   period_out - last rising-to-rising period, period_vld strobes on update
//   high_out   - last measured high time
//   locked     - LOCK_N consecutive periods equal to EXP_DIV
//   mismatch   - strobe, measured period differs from EXP_DIV
//   timeout    - sticky, period counter saturated without an edge
module div_period_meter
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int EXP_DIV = DIV_DEFAULT,
   parameter int LOCK_N  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flag_in,
   output logic [CNT_W-1:0] period_out,
   output logic             period_vld,
   output logic [CNT_W-1:0] high_out,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout
);
   localparam logic [CNT_W-1:0] MAX    = CNT_W'(sat_max(CNT_W));
   localparam logic [CNT_W-1:0] EXP    = CNT_W'(EXP_DIV);
   localparam int               MW     = $clog2(LOCK_N + 1);
   localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_N);

   if (EXP_DIV < 2 || $unsigned(EXP_DIV) > sat_max(CNT_W)) begin : g_bad_exp
      $error("EXP_DIV does not fit in CNT_W bits or is below 2");
   end
   if (LOCK_N < 1) begin : g_bad_lock
      $error("LOCK_N must be at least 1");
   end

   logic             rise, fall;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [MW-1:0]    match_q, match_d;
   logic             vld_q, vld_d;
   logic             mis_q, mis_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;

   edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (flag_in),
      .rise (rise),
      .fall (fall)
   );

   always_comb begin
      cnt_d     = rise ? CNT_W'(1) : (cnt_q == MAX) ? cnt_q : cnt_q + CNT_W'(1);
      hcnt_d    = rise ? CNT_W'(1) : (flag_in && hcnt_q != MAX) ? hcnt_q + CNT_W'(1) : hcnt_q;
      high_d    = (fall && en) ? hcnt_q : high_q;
      state_d   = state_q;
      period_d  = period_q;
      match_d   = match_q;
      vld_d     = 1'b0;
      mis_d     = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      if (!en) begin
         state_d  = IDLE;
         locked_d = 1'b0;
         match_d  = '0;
      end else if (state_q == IDLE) begin
         // the first edge only re-arms: there is no previous edge to measure from
         if (rise) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
         end
      end else if (rise) begin
         // a rise in the saturation cycle is still a valid (long) period
         period_d = cnt_q;
         vld_d    = 1'b1;
         if (cnt_q == EXP) begin
            match_d = (match_q == LOCK_M) ? match_q : match_q + MW'(1);
            if (match_d == LOCK_M) begin
               state_d  = LOCKED;
               locked_d = 1'b1;
            end
         end else begin
            match_d  = '0;
            mis_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = MEASURE;
         end
      end else if (cnt_q == MAX) begin
         timeout_d = 1'b1;
         locked_d  = 1'b0;
         match_d   = '0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         match_q   <= '0;
         vld_q     <= 1'b0;
         mis_q     <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         match_q   <= match_d;
         vld_q     <= vld_d;
         mis_q     <= mis_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign period_out = period_q;
   assign period_vld = vld_q;
   assign high_out   = high_q;
   assign locked     = locked_q;
   assign mismatch   = mis_q;
   assign timeout    = timeout_q;
endmodule

// File: tb/tb_div_period_meter.sv
// tb_div_period_meter: directed checks of the period meter (default and 4-bit instances).
module tb_div_period_meter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic en2 = 1'b0;
   logic flag = 1'b0;
   logic [15:0] per1, hi1;
   logic vld1, lck1, mis1, to1;
   logic [3:0] per2, hi2;
   logic vld2, lck2, mis2, to2;
   logic [15:0] r_per;
   logic r_vld, r_lck, r_mis;
   logic [3:0] s_per;
   logic s_vld, s_lck;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_period_meter #(.CNT_W(16), .EXP_DIV(16), .LOCK_N(4)) dut (
      .clk(clk), .rst(rst), .en(en), .flag_in(flag),
      .period_out(per1), .period_vld(vld1), .high_out(hi1),
      .locked(lck1), .mismatch(mis1), .timeout(to1)
   );

   div_period_meter #(.CNT_W(4), .EXP_DIV(8), .LOCK_N(2)) dut4 (
      .clk(clk), .rst(rst), .en(en2), .flag_in(flag),
      .period_out(per2), .period_vld(vld2), .high_out(hi2),
      .locked(lck2), .mismatch(mis2), .timeout(to2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one flag period of p cycles, high for h; captures outputs right after the rise
   task automatic period(input int p, input int h);
      flag = 1'b1;
      tick();
      r_vld = vld1; r_per = per1; r_mis = mis1; r_lck = lck1;
      s_vld = vld2; s_per = per2; s_lck = lck2;
      for (int i = 1; i < p; i++) begin
         flag = (i < h);
         tick();
      end
   endtask

   task automatic do_reset();
      flag = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      en = 1'b1;
      en2 = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (per1 !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", per1); end
      checks++; if (vld1 !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", vld1); end
      checks++; if (hi1 !== 16'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", hi1); end
      checks++; if (lck1 !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", lck1); end
      checks++; if (mis1 !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%0b exp=0", mis1); end
      checks++; if (to1 !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", to1); end
   endtask

   task automatic test_pulse();
      do_reset();
      period(16, 1);
      checks++; if (r_vld !== 1'b0) begin failures++; $display("FAIL pulse_arm_vld got=%0b exp=0", r_vld); end
      for (int k = 0; k < 4; k++) begin
         period(16, 1);
         checks++; if (r_vld !== 1'b1) begin failures++; $display("FAIL pulse_vld%0d got=%0b exp=1", k, r_vld); end
         checks++; if (r_per !== 16'd16) begin failures++; $display("FAIL pulse_period%0d got=%0d exp=16", k, r_per); end
         checks++; if (r_mis !== 1'b0) begin failures++; $display("FAIL pulse_mismatch%0d got=%0b exp=0", k, r_mis); end
         checks++; if (r_lck !== (k == 3)) begin failures++; $display("FAIL pulse_locked%0d got=%0b exp=%0b", k, r_lck, k == 3); end
      end
   endtask

   task automatic test_square();
      do_reset();
      period(16, 8);
      for (int k = 0; k < 4; k++) begin
         period(16, 8);
         checks++; if (r_per !== 16'd16) begin failures++; $display("FAIL square_period%0d got=%0d exp=16", k, r_per); end
         checks++; if (hi1 !== 16'd8) begin failures++; $display("FAIL square_high%0d got=%0d exp=8", k, hi1); end
         checks++; if (r_lck !== (k == 3)) begin failures++; $display("FAIL square_locked%0d got=%0b exp=%0b", k, r_lck, k == 3); end
      end
   endtask

   task automatic test_mismatch();
      period(15, 1);
      checks++; if (r_lck !== 1'b1) begin failures++; $display("FAIL mis_pre_locked got=%0b exp=1", r_lck); end
      period(16, 1);
      checks++; if (r_mis !== 1'b1) begin failures++; $display("FAIL mis_strobe got=%0b exp=1", r_mis); end
      checks++; if (r_vld !== 1'b1) begin failures++; $display("FAIL mis_vld got=%0b exp=1", r_vld); end
      checks++; if (r_per !== 16'd15) begin failures++; $display("FAIL mis_period got=%0d exp=15", r_per); end
      checks++; if (r_lck !== 1'b0) begin failures++; $display("FAIL mis_locked got=%0b exp=0", r_lck); end
      for (int k = 0; k < 4; k++) begin
         period(16, 1);
         checks++; if (r_lck !== (k == 3)) begin failures++; $display("FAIL relock%0d got=%0b exp=%0b", k, r_lck, k == 3); end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      period(8, 1);
      period(8, 1);
      checks++; if (s_vld !== 1'b1 || s_per !== 4'd8) begin failures++; $display("FAIL to_first vld=%0b per=%0d exp vld=1 per=8", s_vld, s_per); end
      checks++; if (s_lck !== 1'b0) begin failures++; $display("FAIL to_first_locked got=%0b exp=0", s_lck); end
      flag = 1'b1;
      tick();
      checks++; if (lck2 !== 1'b1) begin failures++; $display("FAIL to_locked got=%0b exp=1", lck2); end
      flag = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      checks++; if (to2 !== 1'b0) begin failures++; $display("FAIL to_early got=%0b exp=0", to2); end
      tick();
      checks++; if (to2 !== 1'b1) begin failures++; $display("FAIL to_set got=%0b exp=1", to2); end
      checks++; if (lck2 !== 1'b0) begin failures++; $display("FAIL to_unlock got=%0b exp=0", lck2); end
      checks++; if (per2 !== 4'd8) begin failures++; $display("FAIL to_period_hold got=%0d exp=8", per2); end
      flag = 1'b1;
      tick();
      checks++; if (vld2 !== 1'b0) begin failures++; $display("FAIL to_rearm_vld got=%0b exp=0", vld2); end
      checks++; if (to2 !== 1'b0) begin failures++; $display("FAIL to_clear got=%0b exp=0", to2); end
      flag = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      flag = 1'b1;
      tick();
      checks++; if (vld2 !== 1'b1 || per2 !== 4'd8) begin failures++; $display("FAIL to_remeasure vld=%0b per=%0d exp vld=1 per=8", vld2, per2); end
      flag = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int k = 0; k < 5; k++) period(16, 4);
      checks++; if (r_lck !== 1'b1) begin failures++; $display("FAIL mrst_pre_locked got=%0b exp=1", r_lck); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (per1 !== 16'd0 || hi1 !== 16'd0) begin failures++; $display("FAIL mrst_zero per=%0d high=%0d exp 0 0", per1, hi1); end
      checks++; if (lck1 !== 1'b0 || vld1 !== 1'b0 || mis1 !== 1'b0 || to1 !== 1'b0) begin failures++; $display("FAIL mrst_flags lck=%0b vld=%0b mis=%0b to=%0b exp 0", lck1, vld1, mis1, to1); end
      for (int i = 0; i < 4; i++) tick();
      period(16, 1);
      checks++; if (r_vld !== 1'b0) begin failures++; $display("FAIL mrst_rearm_vld got=%0b exp=0", r_vld); end
      for (int k = 0; k < 4; k++) begin
         period(16, 1);
         checks++; if (r_lck !== (k == 3)) begin failures++; $display("FAIL mrst_lock%0d got=%0b exp=%0b", k, r_lck, k == 3); end
      end
   endtask

   task automatic test_enable();
      en = 1'b0;
      tick();
      checks++; if (lck1 !== 1'b0) begin failures++; $display("FAIL en_unlock got=%0b exp=0", lck1); end
      checks++; if (per1 !== 16'd16) begin failures++; $display("FAIL en_period_hold got=%0d exp=16", per1); end
      for (int i = 0; i < 19; i++) tick();
      checks++; if (per1 !== 16'd16 || lck1 !== 1'b0) begin failures++; $display("FAIL en_idle per=%0d lck=%0b exp per=16 lck=0", per1, lck1); end
      en = 1'b1;
      period(16, 1);
      checks++; if (r_vld !== 1'b0) begin failures++; $display("FAIL en_rearm_vld got=%0b exp=0", r_vld); end
      period(16, 1);
      checks++; if (r_vld !== 1'b1 || r_per !== 16'd16) begin failures++; $display("FAIL en_measure vld=%0b per=%0d exp vld=1 per=16", r_vld, r_per); end
   endtask

   initial begin
      test_reset();
      test_pulse();
      test_square();
      test_mismatch();
      test_timeout();
      test_mid_reset();
      test_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
